// File: rtl/fragment_pkt.sv
// -----------------------------------------------------------------------------
// fragment_pkt
//
// Transmit-side packet fragmenter. Captures one full packet (data, DFX address
// and ACK/SEQ/DFX control fields) from the send controller and writes it into
// the Aurora TX fragment FIFO as NUMBER_FRAG fragments of AURORA_WIDTH bits.
// Each fragment has a 9-bit header followed by the payload slice:
//   [1:0]   source router (ROUTER_ID)
//   [3:2]   destination router (captured with the packet)
//   [6:4]   fragment index
//   [7]     last-fragment flag
//   [8]     payload parity (FRAG_PARITY_EN) or 0
//   [255:9] payload; the final fragment carries the leftover packet bits,
//           zero-padded at the top
//
// Optional feature macro: FRAG_PARITY_EN
//   defined   -> bit [8] is the even-parity bit (XOR) of bits [255:9]
//   undefined -> bit [8] is tied to 0
//
// Ports:
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   valid_pkt_send  in   packet present on pkt_send
//   pkt_send        in   packet to fragment (PKT_WIDTH)
//   dst_router      in   destination router ID (ROUTER_WIDTH)
//   ready_send_pkt  out  block is idle and can accept a packet
//   full_frag_fifo  in   TX fragment FIFO almost-full (one entry of margin)
//   wr_frag_fifo    out  fragment write strobe
//   frag_send       out  fragment data (AURORA_WIDTH)
//   pkt_sent        out  one-cycle pulse with the last fragment write
// -----------------------------------------------------------------------------
module fragment_pkt #(
    parameter int DATA_WIDTH   = 1024,
    parameter int ADDR_WIDTH   = 10,
    parameter int PKT_WIDTH    = 1041,
    parameter int ROUTER_WIDTH = 2,
    parameter int ROUTER_ID    = 0,
    parameter int AURORA_WIDTH = 256,
    parameter int NUMBER_FRAG  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_pkt_send,
    input  logic [PKT_WIDTH-1:0]    pkt_send,
    input  logic [ROUTER_WIDTH-1:0] dst_router,
    output logic                    ready_send_pkt,
    input  logic                    full_frag_fifo,
    output logic                    wr_frag_fifo,
    output logic [AURORA_WIDTH-1:0] frag_send,
    output logic                    pkt_sent
);

    localparam int HDR_W     = 9;
    localparam int PAYLOAD_W = AURORA_WIDTH - HDR_W;
    localparam int CNT_W     = 3;
    localparam int EXT_W     = NUMBER_FRAG * PAYLOAD_W;
    localparam int PAD_W     = EXT_W - PKT_WIDTH;
    localparam int CTRL_W    = PKT_WIDTH - DATA_WIDTH - ADDR_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUMBER_FRAG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [PKT_WIDTH-1:0]    r_pkt;
    logic [ROUTER_WIDTH-1:0] r_dst;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_wr;
    logic                    r_sent;
    logic [AURORA_WIDTH-1:0] r_frag;

    logic [EXT_W-1:0]        w_pkt_ext;
    logic [PAYLOAD_W-1:0]    w_payload;
    logic                    w_last;
    logic                    w_parity;
    logic [HDR_W-1:0]        w_header;

    // Packet is laid out control fields | DFX address | data from the MSB
    // down. Fragments cut straight across those field boundaries, so the
    // packet is simply zero-extended to a whole number of payload slices.
    assign w_pkt_ext = {{PAD_W{1'b0}},
                        r_pkt[PKT_WIDTH-1 -: CTRL_W],
                        r_pkt[DATA_WIDTH +: ADDR_WIDTH],
                        r_pkt[DATA_WIDTH-1:0]};

    assign w_payload = w_pkt_ext[int'(r_cnt) * PAYLOAD_W +: PAYLOAD_W];
    assign w_last    = (r_cnt == LAST_IDX);

`ifdef FRAG_PARITY_EN
    assign w_parity = ^w_payload;
`else
    assign w_parity = 1'b0;
`endif

    assign w_header = {w_parity, w_last, r_cnt, r_dst, ROUTER_WIDTH'(ROUTER_ID)};

    assign ready_send_pkt = (r_state == S_IDLE);
    assign wr_frag_fifo   = r_wr;
    assign frag_send      = r_frag;
    assign pkt_sent       = r_sent;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the capture registers are reset as well, so frag_send and
            // the packet copy never hold data from before the reset.
            r_state <= S_IDLE;
            r_pkt   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_sent  <= 1'b0;
            r_frag  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_wr   <= 1'b0;
                    r_sent <= 1'b0;
                    if (valid_pkt_send) begin
                        r_pkt   <= pkt_send;
                        r_dst   <= dst_router;
                        r_cnt   <= '0;
                        r_state <= S_SEND;
                    end
                end

                S_SEND: begin
                    // full is looked at one cycle ahead of the write, which is
                    // why the FIFO flags almost-full with one entry to spare.
                    if (!full_frag_fifo) begin
                        r_wr   <= 1'b1;
                        r_frag <= {w_payload, w_header};
                        if (w_last) begin
                            r_sent  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_wr <= 1'b0;
                    end
                end

                S_DONE: begin
                    r_wr    <= 1'b0;
                    r_sent  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_wr    <= 1'b0;
                    r_sent  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
